// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - UART RX -> elastic FIFO -> UART TX bridge with loop and host modes
module uart_fifo_bridge #(
  parameter int CLK_FRE     = 50,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst,
  input  logic                          i_uart_rx,
  output logic                          o_uart_tx,
  input  logic                          i_loop_en,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic                          o_rd_valid,
  input  logic                          i_rd_ready,
  input  logic [DATA_WIDTH-1:0]         i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow
);

  localparam int BAUD_DIV = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int STOP_DIV = STOP_BITS * BAUD_DIV;
  localparam int CW       = $clog2(STOP_DIV + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BW       = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = 1'(PARITY_TYPE);

  localparam logic [2:0] RX_IDLE    = 3'd0;
  localparam logic [2:0] RX_START   = 3'd1;
  localparam logic [2:0] RX_DATA    = 3'd2;
  localparam logic [2:0] RX_PARITY  = 3'd3;
  localparam logic [2:0] RX_STOP    = 3'd4;
  localparam logic [2:0] RX_WAIT_HI = 3'd5;

  localparam logic [2:0] TX_IDLE    = 3'd0;
  localparam logic [2:0] TX_START   = 3'd1;
  localparam logic [2:0] TX_DATA    = 3'd2;
  localparam logic [2:0] TX_PARITY  = 3'd3;
  localparam logic [2:0] TX_STOP    = 3'd4;

  logic                  rx_s1, rx_s2, rx_prev;
  logic [2:0]            rx_state;
  logic [CW-1:0]         rx_cnt;
  logic [BW-1:0]         rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_par_bad;
  logic                  rx_push;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic                  empty, full, loop_pop, fifo_pop, push_ok;

  logic [2:0]            tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [BW-1:0]         tx_bit;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par;
  logic                  loop_mode, mode_eff;

  assign empty        = (level == '0);
  assign full         = (level == FULL_LVL);
  assign o_fifo_level = level;
  assign o_rd_data    = mem[rd_ptr];

  // Mode is only re-sampled while TX is idle so an in-flight frame never changes owner
  always_comb begin
    mode_eff   = (tx_state == TX_IDLE) ? i_loop_en : loop_mode;
    o_rd_valid = !empty && !mode_eff && !i_rst;
    o_tx_ready = (tx_state == TX_IDLE) && !mode_eff && !i_rst;
    loop_pop   = (tx_state == TX_IDLE) && mode_eff && !empty;
    fifo_pop   = loop_pop || (o_rd_valid && i_rd_ready);
    push_ok    = rx_push && (!full || fifo_pop);
  end

  // Two-flop synchroniser plus one history flop for start-edge detection
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX frame FSM: mid-bit sampling, parity/stop checks, push request on good byte
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_par_bad   <= 1'b0;
      rx_push      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      rx_push      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_par_bad <= 1'b0;
            rx_state   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
            rx_bit   <= rx_bit + BW'(1);
            if (rx_bit == BIT_LAST) rx_state <= (PARITY_ON != 0) ? RX_PARITY : RX_STOP;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_PARITY: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt     <= '0;
            rx_par_bad <= rx_s2 ^ (^rx_shift) ^ PAR_ODD;
            rx_state   <= RX_STOP;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_STOP: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt <= '0;
            if (rx_par_bad) o_parity_err <= 1'b1;
            else if (!rx_s2) o_frame_err <= 1'b1;
            else rx_push <= 1'b1;
            rx_state <= rx_s2 ? RX_IDLE : RX_WAIT_HI;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_WAIT_HI: if (rx_s2) rx_state <= RX_IDLE;
        default:    rx_state <= RX_IDLE;
      endcase
    end
  end

  // FIFO storage; the byte is stable in rx_shift for the push cycle
  always_ff @(posedge i_clk_sys) begin
    if (push_ok && !i_rst) mem[wr_ptr] <= rx_shift;
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= rx_push && !push_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, fifo_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // TX frame FSM: every bit held BAUD_DIV cycles, line driven from a register
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      loop_mode <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      loop_mode <= mode_eff;
      case (tx_state)
        TX_IDLE: begin
          o_uart_tx <= 1'b1;
          tx_cnt    <= '0;
          if (loop_pop) begin
            tx_shift  <= o_rd_data;
            tx_par    <= (^o_rd_data) ^ PAR_ODD;
            tx_state  <= TX_START;
            o_uart_tx <= 1'b0;
          end else if (o_tx_ready && i_tx_valid) begin
            tx_shift  <= i_tx_data;
            tx_par    <= (^i_tx_data) ^ PAR_ODD;
            tx_state  <= TX_START;
            o_uart_tx <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_state  <= TX_DATA;
            o_uart_tx <= tx_shift[0];
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_DATA: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_state  <= (PARITY_ON != 0) ? TX_PARITY : TX_STOP;
              o_uart_tx <= (PARITY_ON != 0) ? tx_par : 1'b1;
            end else begin
              tx_bit    <= tx_bit + BW'(1);
              tx_shift  <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
              o_uart_tx <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_PARITY: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt    <= '0;
            tx_state  <= TX_STOP;
            o_uart_tx <= 1'b1;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_STOP: begin
          o_uart_tx <= 1'b1;
          if (tx_cnt == STOP_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - directed self-checking bench for uart_fifo_bridge
module tb_uart_fifo_bridge;
  localparam int BD = 50;

  logic       clk = 1'b0;
  logic       rst, rx, rx_p, loop_en, rd_ready, tx_valid;
  logic [7:0] tx_data;
  logic       tx, rd_valid, tx_ready, perr, ferr, ovf;
  logic [7:0] rd_data;
  logic [4:0] level;
  logic       tx_p, rd_valid_p, tx_ready_p, perr_p, ferr_p, ovf_p;
  logic [7:0] rd_data_p;
  logic [4:0] level_p;

  int errors = 0;
  int checks = 0;
  int lat = 480;
  int ovf_cnt = 0, perr_cnt = 0, ferr_cnt = 0, perr_p_cnt = 0, ferr_p_cnt = 0;

  always #5 clk = ~clk;

  uart_fifo_bridge #(.CLK_FRE(50), .BAUD_RATE(1000000)) dut (
    .i_clk_sys(clk), .i_rst(rst), .i_uart_rx(rx), .o_uart_tx(tx), .i_loop_en(loop_en),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_fifo_level(level), .o_parity_err(perr), .o_frame_err(ferr), .o_overflow(ovf));

  uart_fifo_bridge #(.CLK_FRE(50), .BAUD_RATE(1000000), .PARITY_ON(1), .PARITY_TYPE(1)) dut_p (
    .i_clk_sys(clk), .i_rst(rst), .i_uart_rx(rx_p), .o_uart_tx(tx_p), .i_loop_en(1'b0),
    .o_rd_data(rd_data_p), .o_rd_valid(rd_valid_p), .i_rd_ready(1'b0),
    .i_tx_data(8'h00), .i_tx_valid(1'b0), .o_tx_ready(tx_ready_p),
    .o_fifo_level(level_p), .o_parity_err(perr_p), .o_frame_err(ferr_p), .o_overflow(ovf_p));

  // pulse counters: a pulse held for more than one cycle counts more than once
  always @(negedge clk) begin
    if (ovf === 1'b1) ovf_cnt++;
    if (perr === 1'b1) perr_cnt++;
    if (ferr === 1'b1) ferr_cnt++;
    if (perr_p === 1'b1) perr_p_cnt++;
    if (ferr_p === 1'b1) ferr_p_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx_p = v;
    else rx = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop);
    drive_rx(sel, 1'b0);
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, d[i]);
      tick(BD);
    end
    if (has_par) begin
      drive_rx(sel, par);
      tick(BD);
    end
    drive_rx(sel, stop);
    tick(BD);
    drive_rx(sel, 1'b1);
  endtask

  // records the first and last cycle of each of the 10 bit cells of one TX frame
  task automatic capture_frame(output logic [9:0] first, output logic [9:0] last,
                               output int wait_n, output bit tmo);
    first = '0;
    last = '0;
    wait_n = 0;
    tmo = 1'b0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (tx !== 1'b0 && wait_n < 700);
    if (tx !== 1'b0) tmo = 1'b1;
    else begin
      for (int k = 0; k < 10; k++) begin
        first[k] = tx;
        repeat (BD - 1) @(negedge clk);
        last[k] = tx;
        if (k < 9) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; loop_en = 1'b0;
    rd_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(3);
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    checks++; if ({ovf, perr, ferr} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {ovf, perr, ferr}); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL idle_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_rx_host;
    int n;
    n = 0;
    fork
      send_frame(1'b0, 8'h3A, 1'b0, 1'b0, 1'b1);
      begin
        do begin
          @(negedge clk);
          n++;
        end while (level !== 5'd1 && n < 600);
      end
    join
    lat = n;
    checks++; if (n < 451 || n > 503) begin errors++; $display("FAIL rx_push_time: got %0d cycles want 451..503", n); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3A) begin errors++; $display("FAIL rx_data: got v=%b d=%h want v=1 d=3a", rd_valid, rd_data); end
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL rx_pop: got lvl=%0d v=%b want 0 0", level, rd_valid); end
  endtask

  task automatic test_loop;
    logic [9:0] f, l, want;
    int n;
    bit tmo;
    want = {1'b1, 8'hA5, 1'b0};
    loop_en = 1'b1;
    tick(1);
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      capture_frame(f, l, n, tmo);
    join
    checks++; if (tmo) begin errors++; $display("FAIL loop_start: got no start bit want start within 505 cycles"); end
    checks++; if (n < 451 || n > 505) begin errors++; $display("FAIL loop_latency: got %0d want 451..505", n); end
    checks++; if (f !== want) begin errors++; $display("FAIL loop_bits_first: got %b want %b", f, want); end
    checks++; if (l !== want) begin errors++; $display("FAIL loop_bits_last: got %b want %b", l, want); end
    @(negedge clk);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL loop_level: got %0d want 0", level); end
    loop_en = 1'b0;
    tick(2);
  endtask

  task automatic test_overflow;
    int base;
    base = ovf_cnt;
    for (int i = 0; i < 20; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
    tick(5);
    @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", level); end
    checks++; if (ovf_cnt - base != 4) begin errors++; $display("FAIL ovf_pulses: got %0d want 4", ovf_cnt - base); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL ovf_head: got v=%b d=%h want 1 00", rd_valid, rd_data); end
  endtask

  task automatic test_full_pop;
    int base;
    logic [7:0] popped, want;
    base = ovf_cnt;
    popped = 8'hFF;
    fork
      send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 2) @(posedge clk);
        #1 rd_ready = 1'b1;
        @(negedge clk) popped = rd_data;
        @(posedge clk);
        #1 rd_ready = 1'b0;
      end
    join
    tick(5);
    @(negedge clk);
    checks++; if (popped !== 8'h00) begin errors++; $display("FAIL full_pop_data: got %h want 00", popped); end
    checks++; if (ovf_cnt != base) begin errors++; $display("FAIL full_pop_ovf: got %0d pulses want 0", ovf_cnt - base); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_pop_level: got %0d want 16", level); end
    @(posedge clk); #1 rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      want = (i < 15) ? 8'(i + 1) : 8'h77;
      @(negedge clk);
      checks++; if (rd_valid !== 1'b1 || rd_data !== want) begin errors++; $display("FAIL drain_%0d: got v=%b d=%h want 1 %h", i, rd_valid, rd_data, want); end
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", level); end
  endtask

  task automatic test_parity;
    int bp, bf;
    bp = perr_p_cnt;
    bf = ferr_p_cnt;
    send_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    tick(5);
    checks++; if (perr_p_cnt - bp != 1) begin errors++; $display("FAIL parity_err: got %0d pulse cycles want 1", perr_p_cnt - bp); end
    checks++; if (level_p !== 5'd0) begin errors++; $display("FAIL parity_drop: got lvl %0d want 0", level_p); end
    send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    tick(5);
    checks++; if (level_p !== 5'd1 || rd_data_p !== 8'h3C) begin errors++; $display("FAIL parity_good: got lvl=%0d d=%h want 1 3c", level_p, rd_data_p); end
    checks++; if (perr_p_cnt - bp != 1 || ferr_p_cnt != bf) begin errors++; $display("FAIL parity_pulses: got p=%0d f=%0d want 1 0", perr_p_cnt - bp, ferr_p_cnt - bf); end
  endtask

  task automatic test_glitch_frame;
    int bp, bf;
    bp = perr_cnt;
    bf = ferr_cnt;
    rx = 1'b0;
    tick(15);
    rx = 1'b1;
    tick(60);
    checks++; if (level !== 5'd0 || ferr_cnt != bf || perr_cnt != bp) begin errors++; $display("FAIL glitch: got lvl=%0d f=%0d p=%0d want 0 0 0", level, ferr_cnt - bf, perr_cnt - bp); end
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick(10);
    checks++; if (ferr_cnt - bf != 1 || level !== 5'd0) begin errors++; $display("FAIL frame_err: got f=%0d lvl=%0d want 1 0", ferr_cnt - bf, level); end
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    tick(5);
    checks++; if (level !== 5'd1 || rd_data !== 8'hC3) begin errors++; $display("FAIL after_frame_err: got lvl=%0d d=%h want 1 c3", level, rd_data); end
  endtask

  task automatic test_reset_mid_tx;
    logic [9:0] f, l, want;
    int n;
    bit tmo;
    tx_data = 8'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL host_ready: got %b want 1", tx_ready); end
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b0 || tx !== 1'b0) begin errors++; $display("FAIL host_accept: got rdy=%b tx=%b want 0 0", tx_ready, tx); end
    tick(120);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL host_bit1: got %b want 0", tx); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx !== 1'b1 || level !== 5'd0 || tx_ready !== 1'b0) begin errors++; $display("FAIL mid_reset: got tx=%b lvl=%0d rdy=%b want 1 0 0", tx, level, tx_ready); end
    tick(2);
    rst = 1'b0;
    tick(1);
    want = {1'b1, 8'h55, 1'b0};
    tx_data = 8'h55;
    tx_valid = 1'b1;
    fork
      capture_frame(f, l, n, tmo);
      begin
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    checks++; if (tmo || n > 2) begin errors++; $display("FAIL host_start: got tmo=%b wait=%0d want 0 <=2", tmo, n); end
    checks++; if (f !== want || l !== want) begin errors++; $display("FAIL host_frame: got %b/%b want %b", f, l, want); end
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL host_done: got rdy=%b tx=%b want 1 1", tx_ready, tx); end
  endtask

  initial begin
    test_reset();
    test_rx_host();
    test_loop();
    test_overflow();
    test_full_pop();
    test_parity();
    test_glitch_frame();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
